// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
//   Connects an icache and a dcache to one AXI4 master port.
//   Reads: two requesters (bit0 = icache, bit1 = dcache) share the AR/R
//   channels. A round-robin pointer picks the winner, and only one AR is
//   outstanding at a time. Writes: the dcache alone drives AW/W/B through a
//   separate FSM that runs at the same time as the read FSM.
// Ports
//   clk, rst                 : single rising-edge clock, synchronous active-high reset
//   rd_req/rd_addr/rd_len    : per-requester read request, start address, AXI len
//   rd_gnt                   : one-cycle pulse on the AR handshake for the winner
//   rd_rvalid/rd_rdata/...   : read beats steered to the granted requester
//   wr_req/wr_addr/wr_len    : dcache write request
//   wr_dvalid/wr_data/wr_strb, wr_dready : write beat stream
//   wr_done/wr_resp          : completion pulse with the captured bresp
//   ar*/r*/aw*/w*/b*         : AXI4 master channels
module axi_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rd_req,
  input  logic [2*ADDR_W-1:0]   rd_addr,
  input  logic [15:0]           rd_len,
  output logic [1:0]            rd_gnt,
  output logic [1:0]            rd_rvalid,
  output logic [DATA_W-1:0]     rd_rdata,
  output logic                  rd_rlast,
  output logic                  rd_err,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_len,
  input  logic                  wr_dvalid,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  output logic                  wr_dready,
  output logic                  wr_done,
  output logic [1:0]            wr_resp,
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  r_state_t           r_state;
  w_state_t           w_state;
  logic               r_win;
  logic               rr_last;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_len;
  logic [ADDR_W-1:0]  w_addr;
  logic [7:0]         w_len;
  logic [7:0]         w_cnt;
  logic [1:0]         rd_elig;
  logic               pick;
  logic [1:0]         win_onehot;
  logic               w_hs;

  // Response IDs are not checked: only one transaction per channel is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  // The dcache may not read while its own write is in flight. A write request
  // that arrives in the same cycle also blocks it, because the write is latched first.
  assign rd_elig    = {rd_req[1] & (w_state == W_IDLE) & ~wr_req, rd_req[0]};
  // rr_last holds the index granted last; on a tie the other requester wins.
  assign pick       = (rd_elig == 2'b11) ? ~rr_last : rd_elig[1];
  assign win_onehot = r_win ? 2'b10 : 2'b01;

  assign arid    = ID_W'(r_win);
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign rd_gnt    = (r_state == R_AR && arvalid && arready) ? win_onehot : 2'b00;
  assign rd_rvalid = (r_state == R_DATA && rvalid) ? win_onehot : 2'b00;
  assign rd_rdata  = rdata;
  assign rd_rlast  = rlast;
  assign rd_err    = |rresp;

  // Read FSM. Reset abandons any burst in flight and re-arms icache priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_win   <= 1'b0;
      rr_last <= 1'b1;
      r_addr  <= '0;
      r_len   <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (|rd_elig) begin
            r_win   <= pick;
            rr_last <= pick;
            r_addr  <= pick ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];
            r_len   <= pick ? rd_len[15:8] : rd_len[7:0];
            arvalid <= 1'b1;
            r_state <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rlast) begin
            rready  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: begin
          arvalid <= 1'b0;
          rready  <= 1'b0;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  assign awid    = ID_W'(2);
  assign awaddr  = w_addr;
  assign awlen   = w_len;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid       = ID_W'(2);
  assign wdata     = wr_data;
  assign wstrb     = wr_strb;
  assign wvalid    = (w_state == W_DATA) & wr_dvalid;
  assign wr_dready = (w_state == W_DATA) & wready;
  assign wlast     = (w_state == W_DATA) & (w_cnt == w_len);
  assign w_hs      = wvalid & wready;

  // Write FSM. wr_done is a registered pulse, so it appears one cycle after bvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      awvalid <= 1'b0;
      bready  <= 1'b0;
      wr_done <= 1'b0;
      wr_resp <= 2'b00;
    end else begin
      wr_done <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (wr_req) begin
            w_addr  <= wr_addr;
            w_len   <= wr_len;
            w_cnt   <= '0;
            awvalid <= 1'b1;
            w_state <= W_AW;
          end
        end
        W_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              bready  <= 1'b1;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            wr_done <= 1'b1;
            wr_resp <= bresp;
            w_state <= W_IDLE;
          end
        end
        default: begin
          awvalid <= 1'b0;
          bready  <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

endmodule
